// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// master = fetch side (drives requests), slave = memory side (drives responses).
//   req_valid/req_addr : fetch request, word-aligned 64-bit address
//   req_ready          : memory accepts the request this cycle
//   rsp_valid/rsp_data : in-order 32-bit instruction response
interface if_fetch_unit_if;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited fetch requests,
// prefetch FIFO of in-order responses, redirect with stale-response drop.
// Ports:
//   clk, rst (async, active low)
//   imem         : if_fetch_unit_if.master, request/response bus
//   jump_en_i    : redirect from ex, jump_addr_i target
//   hold_i       : downstream stall, head is not popped
//   inst_o, inst_addr_o, inst_valid_o : FIFO head to if_id
//   misalign_o   : only with IFU_MISALIGN_TRAP_EN, pulses on a misaligned
//                  redirect; the stage then halts until an aligned redirect
// Optional feature macro: IFU_MISALIGN_TRAP_EN
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC        = 64'h8000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         rst,
    if_fetch_unit_if.master imem,
    input  logic         jump_en_i,
    input  logic [63:0]  jump_addr_i,
    input  logic         hold_i,
    output logic [31:0]  inst_o,
    output logic [63:0]  inst_addr_o,
    output logic         inst_valid_o
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic         misalign_o
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);
    localparam cnt_t MAX_C   = cnt_t'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN
`ifdef IFU_MISALIGN_TRAP_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [63:0] r_fetch_pc;
    logic [63:0] r_rsp_pc;
    cnt_t        r_count;
    cnt_t        r_out;
    cnt_t        r_drop;
    ptr_t        r_wptr;
    ptr_t        r_rptr;

    logic [31:0] r_fifo_inst [FIFO_DEPTH];
    logic [63:0] r_fifo_addr [FIFO_DEPTH];

    logic [63:0] w_jaddr;
    logic        w_empty;
    logic        w_full;
    cnt_t        w_credit;
    logic        w_can_issue;
    logic        w_req_valid;
    logic        w_hs;
    logic        w_rsp;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    cnt_t        w_out_nxt;

`ifdef IFU_MISALIGN_TRAP_EN
    logic        r_misalign;
    logic        w_misal;

    assign w_jaddr = jump_addr_i;
    assign w_misal = jump_en_i && (jump_addr_i[1:0] != 2'b00);
    assign misalign_o = r_misalign;
`else
    logic        w_unused_lo;

    // Low target bits are ignored: the target is forced word aligned.
    assign w_jaddr     = {jump_addr_i[63:2], 2'b00};
    assign w_unused_lo = ^jump_addr_i[1:0];
`endif

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // FIFO slots already claimed: buffered entries plus live requests.
    // Requests that will be dropped do not need a slot.
    assign w_credit    = r_count + r_out - r_drop;
    assign w_can_issue = (r_out < MAX_C) && (w_credit < DEPTH_C);

    assign w_hs   = w_req_valid && imem.req_ready;
    assign w_rsp  = imem.rsp_valid;
    assign w_drop = w_rsp && (r_drop != '0);
    assign w_push = w_rsp && (r_drop == '0) && !jump_en_i;
    assign w_pop  = !w_empty && !hold_i && !jump_en_i;

    assign w_out_nxt = r_out + cnt_t'(w_hs) - cnt_t'(w_rsp);

    assign imem.req_valid = w_req_valid;
    assign imem.req_addr  = r_fetch_pc;

    assign inst_valid_o = !w_empty;
    assign inst_o       = w_empty ? NOP   : r_fifo_inst[r_rptr];
    assign inst_addr_o  = w_empty ? '0    : r_fifo_addr[r_rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_req_valid = w_can_issue && !jump_en_i;
            end
`ifdef IFU_MISALIGN_TRAP_EN
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
`endif
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
        if (jump_en_i) begin
`ifdef IFU_MISALIGN_TRAP_EN
            w_state_nxt = w_misal ? S_HALT : S_RUN;
`else
            w_state_nxt = S_RUN;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_count    <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_out <= w_out_nxt;
            if (jump_en_i) begin
                r_fetch_pc <= w_jaddr;
                r_rsp_pc   <= w_jaddr;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                // Everything still in flight after this cycle is stale.
                r_drop     <= w_out_nxt;
            end else begin
                if (w_hs) begin
                    r_fetch_pc <= r_fetch_pc + 64'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 64'd4;
                    r_wptr   <= r_wptr + ptr_t'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + ptr_t'(1);
                end
                r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
                if (w_drop) begin
                    r_drop <= r_drop - cnt_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_inst[r_wptr] <= imem.rsp_data;
            r_fifo_addr[r_wptr] <= r_rsp_pc;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misal;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(w_rsp && (r_out == '0)))
                else $error("imem response with nothing outstanding");
            assert (!(w_push && w_full))
                else $error("prefetch FIFO overflow");
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model, queue-based
// reference of the expected instruction stream, directed + random phases.
module tb_if_fetch_unit;

    localparam logic [63:0] RPC   = 64'h8000_0000;
    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en;
    logic [63:0] jump_addr;
    logic        hold;
    logic [31:0] inst_o;
    logic [63:0] inst_addr_o;
    logic        inst_valid_o;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    if_fetch_unit_if imem ();

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (imem.master),
        .jump_en_i    (jump_en),
        .jump_addr_i  (jump_addr),
        .hold_i       (hold),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
`ifdef IFU_MISALIGN_TRAP_EN
        ,
        .misalign_o   (misalign_o)
`endif
    );

    typedef struct {
        logic [63:0] addr;
        int          ep;
    } req_t;

    req_t        pend[$];
    logic [63:0] q[$];
    logic [63:0] seen[$];
    logic [63:0] req_pc;
    int          epoch;
    bit          halted;
    bit          boot;
    bit          mis_exp;
    bit          prev_rv;
    bit          prev_acc;
    logic [63:0] prev_ra;
    bit          last_rv;
    int          cyc;
    int          first_req_cyc;
    logic [63:0] first_req_addr;
    int          p_ready;
    int          p_rsp;
    int          p_hold;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic zero_wait();
        p_ready = 100;
        p_rsp   = 100;
        p_hold  = 0;
    endtask

    // One cycle; called at a falling edge, returns at the next one.
    task automatic step(input bit jmp, input logic [63:0] ja);
        bit   rsp;
        bit   hs;
        bit   pop;
        bit   mis;
        req_t e;
        int   live;
        chk("inst_valid", inst_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            chk("inst_addr", inst_addr_o, q[0]);
            chk("inst_data", inst_o, mem_word(q[0]));
        end else begin
            chk("idle_inst", inst_o, NOP);
            chk("idle_addr", inst_addr_o, 64'd0);
        end
`ifdef IFU_MISALIGN_TRAP_EN
        chk("misalign", misalign_o, mis_exp);
`endif
        hold = $urandom_range(99) < p_hold;
        imem.req_ready = $urandom_range(99) < p_ready;
        rsp = (pend.size() != 0) && ($urandom_range(99) < p_rsp);
        imem.rsp_valid = rsp;
        imem.rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom();
        jump_en   = jmp;
        jump_addr = ja;
        #1;
        last_rv = imem.req_valid;
        if (jmp || halted || boot)
            chk("req_idle", imem.req_valid, 1'b0);
        if (imem.req_valid)
            chk("req_addr", imem.req_addr, req_pc);
        if (prev_rv && !prev_acc && !jmp) begin
            chk("req_stable_v", imem.req_valid, 1'b1);
            chk("req_stable_a", imem.req_addr, prev_ra);
        end
        hs = imem.req_valid && imem.req_ready;
        if (imem.req_valid && first_req_cyc < 0) begin
            first_req_cyc  = cyc;
            first_req_addr = imem.req_addr;
        end
        prev_rv  = imem.req_valid;
        prev_acc = hs;
        prev_ra  = imem.req_addr;
        pop = (q.size() != 0) && !hold && !jmp;
        if (pop) begin
            seen.push_back(inst_addr_o);
            void'(q.pop_front());
        end
        if (rsp) begin
            e = pend.pop_front();
            if (!jmp && e.ep == epoch)
                q.push_back(e.addr);
        end
        mis = 1'b0;
        if (jmp) begin
            q.delete();
            epoch++;
`ifdef IFU_MISALIGN_TRAP_EN
            mis    = ja[1:0] != 2'b00;
            halted = mis;
`endif
            req_pc = {ja[63:2], 2'b00};
        end
        mis_exp = mis;
        if (hs) begin
            pend.push_back('{addr: req_pc, ep: epoch});
            req_pc = req_pc + 64'd4;
        end
        live = q.size();
        foreach (pend[i])
            if (pend[i].ep == epoch)
                live++;
        chk("credit", (pend.size() <= MAXO) && (live <= DEPTH), 1'b1);
        boot = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        jump_en        = 1'b0;
        jump_addr      = '0;
        hold           = 1'b0;
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = '0;
        #1;
        chk("rst_valid", inst_valid_o, 1'b0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_addr", inst_addr_o, 64'd0);
        chk("rst_req", imem.req_valid, 1'b0);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("rst_mis", misalign_o, 1'b0);
`endif
        pend.delete();
        q.delete();
        seen.delete();
        req_pc        = RPC;
        epoch         = 0;
        halted        = 1'b0;
        boot          = 1'b1;
        mis_exp       = 1'b0;
        prev_rv       = 1'b0;
        prev_acc      = 1'b0;
        prev_ra       = '0;
        cyc           = 0;
        first_req_cyc = -1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_valid(input string name, output logic [63:0] a);
        for (int n = 0; n < 40; n++) begin
            if (inst_valid_o)
                break;
            step(1'b0, 64'd0);
        end
        chk(name, inst_valid_o, 1'b1);
        a = inst_addr_o;
    endtask

    function automatic logic [63:0] gen_target();
        logic [63:0] t;
        if ($urandom_range(9) == 0)
            t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'({$urandom_range(3), 2'b00});
        else
            t = RPC + 64'({$urandom_range(255), 2'b00});
        if ($urandom_range(9) == 0)
            t[1:0] = 2'($urandom_range(3));
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        zero_wait();
        @(negedge clk);

        // Boot, first request, back-to-back stream
        do_reset();
        repeat (10) step(1'b0, 64'd0);
        chk("s1_first_cyc", first_req_cyc, 1);
        chk("s1_first_addr", first_req_addr, 64'h8000_0000);
        chk("s1_count", seen.size(), 7);
        chk("s1_seq0", seen[0], 64'h8000_0000);
        chk("s1_seq1", seen[1], 64'h8000_0004);
        chk("s1_seq2", seen[2], 64'h8000_0008);

        // Memory stalls the first request for 3 cycles
        do_reset();
        p_ready = 0;
        step(1'b0, 64'd0);
        repeat (3) begin
            step(1'b0, 64'd0);
            chk("s2_rv", last_rv, 1'b1);
            chk("s2_ra", prev_ra, 64'h8000_0000);
        end
        p_ready = 100;
        step(1'b0, 64'd0);
        chk("s2_hs", pend.size(), 1);

        // Downstream hold fills the FIFO and stops fetch
        do_reset();
        zero_wait();
        repeat (6) step(1'b0, 64'd0);
        p_hold = 100;
        repeat (10) step(1'b0, 64'd0);
        chk("s3_frozen", inst_addr_o, 64'h8000_000C);
        chk("s3_valid", inst_valid_o, 1'b1);
        chk("s3_stop", last_rv, 1'b0);
        chk("s3_full", q.size(), 4);
        p_hold = 0;
        repeat (8) step(1'b0, 64'd0);

        // Redirect with two requests in flight
        do_reset();
        p_ready = 100;
        p_rsp   = 0;
        p_hold  = 0;
        step(1'b0, 64'd0);
        step(1'b1, 64'h8000_0010);
        repeat (3) step(1'b0, 64'd0);
        chk("s4_inflight", pend.size(), 2);
        chk("s4_stop", last_rv, 1'b0);
        p_rsp = 100;
        step(1'b1, 64'h8000_0100);
        wait_valid("s4_wait", a);
        chk("s4_addr", a, 64'h8000_0100);
        repeat (4) step(1'b0, 64'd0);

        // Back-to-back redirects: last one wins
        repeat (3) step(1'b0, 64'd0);
        step(1'b1, 64'h8000_0200);
        step(1'b1, 64'h8000_0300);
        wait_valid("s5_wait", a);
        chk("s5_addr", a, 64'h8000_0300);

        // PC wraps at the top of the address space
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        seen.delete();
        repeat (8) step(1'b0, 64'd0);
        chk("wrap_fffc", seen[1], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_zero", seen[2], 64'h0);
        chk("wrap_four", seen[3], 64'h4);

`ifdef IFU_MISALIGN_TRAP_EN
        // Misaligned redirect halts until an aligned one
        step(1'b1, 64'h8000_0102);
        chk("s6_pulse", misalign_o, 1'b1);
        step(1'b0, 64'd0);
        chk("s6_pulse_end", misalign_o, 1'b0);
        repeat (3) step(1'b0, 64'd0);
        chk("s6_noreq", last_rv, 1'b0);
        chk("s6_noinst", inst_valid_o, 1'b0);
        step(1'b1, 64'h8000_0200);
        wait_valid("s6_wait", a);
        chk("s6_addr", a, 64'h8000_0200);
`else
        // Low target bits are ignored without the trap feature
        step(1'b1, 64'h8000_0402);
        wait_valid("align_wait", a);
        chk("align_addr", a, 64'h8000_0400);
`endif

        // Random traffic, with a reset in the middle
        do_reset();
        for (int seg = 0; seg < 30; seg++) begin
            if (seg == 15)
                do_reset();
            p_ready = $urandom_range(30, 100);
            p_rsp   = $urandom_range(20, 100);
            p_hold  = $urandom_range(0, 60);
            repeat (100) step($urandom_range(99) < 4, gen_target());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
